// File: rtl/prbs8_pkg.sv
// Shared definitions for the 8-bit Fibonacci PRBS generator and checker.
// Polynomial x^8+x^6+x^5+x^4+1; taps on bits 7,5,4,3; new bit enters bit 0.
package prbs8_pkg;

    localparam int LFSR_WIDTH = 8;
    localparam logic [LFSR_WIDTH-1:0] TAP = 8'b1011_1000;

    typedef enum logic [1:0] {
        HUNT   = 2'b00,
        VERIFY = 2'b01,
        LOCKED = 2'b10
    } state_t;

    // Feedback (next emitted) bit for a given register value: parity of tapped bits.
    function automatic logic prbs8_next(input logic [LFSR_WIDTH-1:0] s);
        return ^(s & TAP);
    endfunction

endpackage

// File: rtl/prbs8_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; a clear coincident with an
// increment leaves the count at one so that error is not lost.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_r;

    // Count register: clear has priority, increment stops at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {WIDTH{1'b0}};
        end else if (clr) begin
            count_r <= inc ? {{(WIDTH-1){1'b0}}, 1'b1} : {WIDTH{1'b0}};
        end else if (inc && (count_r != {WIDTH{1'b1}})) begin
            count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/prbs8_checker.sv
// Self-synchronising checker for the prbs8 serial stream. Fills its register
// from the line, verifies a run of correct predictions, then flywheels on its
// own prediction and counts mismatches as bit errors.
module prbs8_checker
    import prbs8_pkg::*;
#(
    parameter int LOCK_COUNT   = 16,
    parameter int UNLOCK_COUNT = 4,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i,
    input  logic                   i_valid,
    input  logic                   clr,
    output logic                   locked,
    output logic                   err,
    output logic [COUNT_WIDTH-1:0] err_count
);

    localparam int FILL_W  = $clog2(LFSR_WIDTH + 1);
    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int RUN_W   = $clog2(UNLOCK_COUNT + 1);

    state_t                  state_r, state_s;
    logic [LFSR_WIDTH-1:0]   sreg_r, sreg_s;
    logic [FILL_W-1:0]       fill_r, fill_s;
    logic [MATCH_W-1:0]      match_r, match_s;
    logic [RUN_W-1:0]        errrun_r, errrun_s;
    logic                    locked_r, err_r, err_s, inc_s, p_s;

    assign p_s = prbs8_next(sreg_r);

    // Next-state logic: acts only on valid bits; ERR defaults low every cycle.
    always_comb begin
        state_s  = state_r;
        sreg_s   = sreg_r;
        fill_s   = fill_r;
        match_s  = match_r;
        errrun_s = errrun_r;
        err_s    = 1'b0;
        inc_s    = 1'b0;
        if (i_valid) begin
            case (state_r)
                HUNT: begin
                    sreg_s = {sreg_r[LFSR_WIDTH-2:0], i};
                    fill_s = fill_r + FILL_W'(1);
                    if (fill_r == FILL_W'(LFSR_WIDTH - 1)) begin
                        state_s = VERIFY;
                        match_s = {MATCH_W{1'b0}};
                    end else begin
                        state_s = HUNT;
                    end
                end
                VERIFY: begin
                    sreg_s = {sreg_r[LFSR_WIDTH-2:0], i};
                    // An all-zero register predicts zeros forever; never trust it.
                    if ((i == p_s) && (sreg_r != {LFSR_WIDTH{1'b0}})) begin
                        match_s = match_r + MATCH_W'(1);
                        if (match_r == MATCH_W'(LOCK_COUNT - 1)) begin
                            state_s  = LOCKED;
                            errrun_s = {RUN_W{1'b0}};
                        end else begin
                            state_s = VERIFY;
                        end
                    end else begin
                        state_s = HUNT;
                        fill_s  = {FILL_W{1'b0}};
                    end
                end
                LOCKED: begin
                    // Flywheel: shift in the prediction so a line error stays isolated.
                    sreg_s = {sreg_r[LFSR_WIDTH-2:0], p_s};
                    if (i != p_s) begin
                        err_s = 1'b1;
                        inc_s = 1'b1;
                        if (errrun_r == RUN_W'(UNLOCK_COUNT - 1)) begin
                            state_s  = HUNT;
                            fill_s   = {FILL_W{1'b0}};
                            errrun_s = {RUN_W{1'b0}};
                        end else begin
                            errrun_s = errrun_r + RUN_W'(1);
                        end
                    end else begin
                        errrun_s = {RUN_W{1'b0}};
                    end
                end
                default: begin
                    state_s = HUNT;
                    fill_s  = {FILL_W{1'b0}};
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State, shift register, run counters and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= HUNT;
            sreg_r   <= {LFSR_WIDTH{1'b0}};
            fill_r   <= {FILL_W{1'b0}};
            match_r  <= {MATCH_W{1'b0}};
            errrun_r <= {RUN_W{1'b0}};
            locked_r <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            state_r  <= state_s;
            sreg_r   <= sreg_s;
            fill_r   <= fill_s;
            match_r  <= match_s;
            errrun_r <= errrun_s;
            locked_r <= (state_s == LOCKED);
            err_r    <= err_s;
        end
    end

    sat_counter #(.WIDTH(COUNT_WIDTH)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc_s),
        .clr   (clr),
        .count (err_count)
    );

    assign locked = locked_r;
    assign err    = err_r;

endmodule
